// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types and constants for the dual-issue FIFO reader
package fifo_reader_pkg;
    localparam int READ_PORT = 2;
    localparam int ENTRY_W   = 32;

    typedef logic [1:0] pop_num_t;

    typedef struct packed {
        logic [READ_PORT-1:0]              valid;
        logic [READ_PORT-1:0][ENTRY_W-1:0] data;
    } issue_pair_t;
endpackage

// File: rtl/fifo_dual_issue_pair_check.sv
// fifo_dual_issue_pair_check: decides how many head entries (0/1/2) to pop this cycle
//   valid[1:0] : per-lane FIFO valid, lane 0 oldest
//   solo[1:0]  : per-lane "must issue alone" flag taken from each head entry
//   can_load   : issue register can accept a new pair this cycle
//   flush      : suppresses any pop
//   n          : pop count
module fifo_dual_issue_pair_check
    import fifo_reader_pkg::*;
(
    input  logic [1:0] valid,
    input  logic [1:0] solo,
    input  logic       can_load,
    input  logic       flush,
    output pop_num_t   n
);
    // valid=10 falls into the n=0 branch because lane 0 is not valid
    always_comb begin
        n = (~valid[0] | ~can_load | flush)  ? 2'd0 :
            (~valid[1] | solo[0] | solo[1]) ? 2'd1 : 2'd2;
    end
endmodule

// File: rtl/fifo_dual_issue_reader.sv
// fifo_dual_issue_reader: pops up to two FIFO head entries per cycle into a two-slot issue register
//   clk, rst_n       : clock, synchronous active-low reset
//   flush_i          : pipeline flush, drops both slots and blocks popping
//   fifo_valid_i     : per-lane FIFO valid; fifo_data_i: head entries, lane 0 oldest
//   fifo_ready_o     : pop request; fifo_num_o: pop count 0..2
//   issue_valid_o    : registered slot valids; issue_data_o: registered slot data
//   issue_ready_i    : downstream consumes both occupied slots this cycle
//   FIFO_DUAL_ISSUE_READER_PERF_EN adds perf_dual_o, perf_single_o, perf_stall_o counters
module fifo_dual_issue_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SOLO_BIT   = 0,
    parameter int READ_PORT  = fifo_reader_pkg::READ_PORT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic [1:0]                 fifo_valid_i,
    input  logic [1:0][DATA_WIDTH-1:0] fifo_data_i,
    output logic                       fifo_ready_o,
    output logic [1:0]                 fifo_num_o,
    output logic [1:0]                 issue_valid_o,
    output logic [1:0][DATA_WIDTH-1:0] issue_data_o,
`ifdef FIFO_DUAL_ISSUE_READER_PERF_EN
    output logic [31:0]                perf_dual_o,
    output logic [31:0]                perf_single_o,
    output logic [31:0]                perf_stall_o,
`endif
    input  logic                       issue_ready_i
);
    logic     can_load;
    pop_num_t n;

    assign can_load = ~(|issue_valid_o) | issue_ready_i;

    // holding reset through the flush input keeps the pop request low during reset
    fifo_dual_issue_pair_check u_check (
        .valid    (fifo_valid_i),
        .solo     ({fifo_data_i[1][SOLO_BIT], fifo_data_i[0][SOLO_BIT]}),
        .can_load (can_load),
        .flush    (flush_i | ~rst_n),
        .n        (n)
    );

    assign fifo_ready_o = (n != 2'd0);
    assign fifo_num_o   = n;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i)
            issue_valid_o <= 2'b00;
        else if (can_load)
            issue_valid_o <= {n == 2'd2, n != 2'd0};
    end

    // slot data carries no reset; it is qualified by issue_valid_o
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && can_load) begin
            if (n != 2'd0) issue_data_o[0] <= fifo_data_i[0];
            if (n == 2'd2) issue_data_o[1] <= fifo_data_i[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n)
            assert (fifo_valid_i != 2'b10)
            else $warning("protocol violation: fifo_valid_i=10 treated as 00");
    end

`ifdef FIFO_DUAL_ISSUE_READER_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_dual_o   <= '0;
            perf_single_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (n == 2'd2) perf_dual_o <= perf_dual_o + 32'd1;
            if (n == 2'd1) perf_single_o <= perf_single_o + 32'd1;
            if (fifo_valid_i[0] && n == 2'd0 && !flush_i) perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_dual_issue_reader.sv
// tb_fifo_dual_issue_reader: directed self-checking bench for fifo_dual_issue_reader
module tb_fifo_dual_issue_reader;
    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_i;
    logic [1:0]       fifo_valid_i;
    logic [1:0][31:0] fifo_data_i;
    logic             fifo_ready_o;
    logic [1:0]       fifo_num_o;
    logic [1:0]       issue_valid_o;
    logic [1:0][31:0] issue_data_o;
    logic             issue_ready_i;
`ifdef FIFO_DUAL_ISSUE_READER_PERF_EN
    logic [31:0]      perf_dual_o, perf_single_o, perf_stall_o;
`endif
    int checks = 0;
    int errors = 0;

    fifo_dual_issue_reader #(.DATA_WIDTH(32), .SOLO_BIT(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .fifo_valid_i  (fifo_valid_i),
        .fifo_data_i   (fifo_data_i),
        .fifo_ready_o  (fifo_ready_o),
        .fifo_num_o    (fifo_num_o),
        .issue_valid_o (issue_valid_o),
        .issue_data_o  (issue_data_o),
`ifdef FIFO_DUAL_ISSUE_READER_PERF_EN
        .perf_dual_o   (perf_dual_o),
        .perf_single_o (perf_single_o),
        .perf_stall_o  (perf_stall_o),
`endif
        .issue_ready_i (issue_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                         input logic rdy, input logic fl);
        fifo_valid_i   = v;
        fifo_data_i[0] = d0;
        fifo_data_i[1] = d1;
        issue_ready_i  = rdy;
        flush_i        = fl;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'b11, 32'h10, 32'h20, 1'b1, 1'b0);
        chk("rst_ready", {31'd0, fifo_ready_o}, 32'd0);
        chk("rst_num", {30'd0, fifo_num_o}, 32'd0);
        tick();
        tick();
        chk("rst_valid", {30'd0, issue_valid_o}, 32'd0);
        rst_n = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("idle_ready", {31'd0, fifo_ready_o}, 32'd0);
        tick();
        chk("idle_valid", {30'd0, issue_valid_o}, 32'd0);

        drive(2'b11, 32'h10, 32'h20, 1'b1, 1'b0);
        chk("dual_num", {30'd0, fifo_num_o}, 32'd2);
        chk("dual_ready", {31'd0, fifo_ready_o}, 32'd1);
        tick();
        chk("dual_valid", {30'd0, issue_valid_o}, 32'd3);
        chk("dual_d0", issue_data_o[0], 32'h10);
        chk("dual_d1", issue_data_o[1], 32'h20);

        drive(2'b11, 32'h11, 32'h20, 1'b1, 1'b0);
        chk("solo0_num", {30'd0, fifo_num_o}, 32'd1);
        tick();
        chk("solo0_valid", {30'd0, issue_valid_o}, 32'd1);
        chk("solo0_d0", issue_data_o[0], 32'h11);
        drive(2'b01, 32'h20, 32'h0, 1'b1, 1'b0);
        chk("b_num", {30'd0, fifo_num_o}, 32'd1);
        tick();
        chk("b_valid", {30'd0, issue_valid_o}, 32'd1);
        chk("b_d0", issue_data_o[0], 32'h20);

        drive(2'b11, 32'h40, 32'h41, 1'b1, 1'b0);
        chk("solo1_num", {30'd0, fifo_num_o}, 32'd1);
        tick();
        chk("solo1_d0", issue_data_o[0], 32'h40);

        drive(2'b11, 32'h30, 32'h40, 1'b1, 1'b0);
        tick();
        chk("fill_valid", {30'd0, issue_valid_o}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 32'h50, 32'h60, 1'b0, 1'b0);
            chk("stall_ready", {31'd0, fifo_ready_o}, 32'd0);
            chk("stall_num", {30'd0, fifo_num_o}, 32'd0);
            tick();
            chk("stall_valid", {30'd0, issue_valid_o}, 32'd3);
            chk("stall_d0", issue_data_o[0], 32'h30);
            chk("stall_d1", issue_data_o[1], 32'h40);
        end
        drive(2'b11, 32'h50, 32'h60, 1'b1, 1'b0);
        chk("resume_num", {30'd0, fifo_num_o}, 32'd2);
        tick();
        chk("resume_valid", {30'd0, issue_valid_o}, 32'd3);
        chk("resume_d0", issue_data_o[0], 32'h50);
        chk("resume_d1", issue_data_o[1], 32'h60);

        drive(2'b11, 32'h70, 32'h80, 1'b1, 1'b1);
        chk("flush_ready", {31'd0, fifo_ready_o}, 32'd0);
        tick();
        chk("flush_valid", {30'd0, issue_valid_o}, 32'd0);

        drive(2'b10, 32'h70, 32'h80, 1'b1, 1'b0);
        chk("proto_num", {30'd0, fifo_num_o}, 32'd0);
        chk("proto_ready", {31'd0, fifo_ready_o}, 32'd0);
        tick();
        chk("proto_valid", {30'd0, issue_valid_o}, 32'd0);

        drive(2'b11, 32'h90, 32'hA0, 1'b1, 1'b0);
        tick();
        chk("pre_rst_valid", {30'd0, issue_valid_o}, 32'd3);
        rst_n = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("midrst_valid", {30'd0, issue_valid_o}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 32'h100 + 32'(i * 4), 32'h102 + 32'(i * 4), 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 32'h200 + 32'(i * 2), 32'h0, 1'b1, 1'b0);
            tick();
        end
        chk("single_d0", issue_data_o[0], 32'h204);
        drive(2'b01, 32'h300, 32'h0, 1'b0, 1'b0);
        chk("full_stall_num", {30'd0, fifo_num_o}, 32'd0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
`ifdef FIFO_DUAL_ISSUE_READER_PERF_EN
        chk("perf_dual", perf_dual_o, 32'd5);
        chk("perf_single", perf_single_o, 32'd3);
        chk("perf_stall", perf_stall_o, 32'd1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
